udp_frame_arbiter: RTL and testbench

//  Frame-atomic round-robin scheduler sharing one UDP parser input FIFO among N_REQ upstream framed byte FIFOs.

---
 rtl/udp_arb_pkg.sv | 18 +
 rtl/udp_frame_arbiter_rr_arbiter.sv | 31 +++
 rtl/udp_frame_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_udp_frame_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_arb_pkg.sv
// Shared types and widths for the UDP frame arbiter.
//   arb_state_t  : arbiter FSM state encoding (IDLE / STREAM / FLUSH)
//   BYTE_W       : payload byte width
//   FRAME_CNT_W  : width of each per-requester completed-frame counter
//   LEN_CNT_W    : width of the in-frame byte counter
package udp_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_STREAM,
    ARB_FLUSH
  } arb_state_t;

  localparam int BYTE_W      = 8;
  localparam int FRAME_CNT_W = 16;
  localparam int LEN_CNT_W   = 16;

endpackage

// File: rtl/udp_frame_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Returns the first asserted request at or after the pointer, wrapping
// around, as a one-hot grant plus a valid flag.
// Ports:
//   i_req   [N-1:0]          request vector
//   i_ptr   [$clog2(N)-1:0]  highest-priority index for this pick
//   o_grant [N-1:0]          one-hot winner (zero when nothing requests)
//   o_valid                  at least one request present
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant,
  output logic                 o_valid
);

  // Scan the N positions starting from the pointer; the first hit wins and
  // o_valid suppresses any later hits in the same scan.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_valid && i_req[(int'(i_ptr) + k) % N]) begin
        o_grant[(int'(i_ptr) + k) % N] = 1'b1;
        o_valid                         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_frame_arbiter.sv
// Frame-atomic round-robin scheduler: shares one downstream byte FIFO write
// port among N_REQ first-word-fall-through framed requester FIFOs. A granted
// requester streams one whole frame (sof..eof) before re-arbitration.
// Leading non-sof bytes at the start of a grant are discarded (resync) and
// frames longer than MAX_FRAME_LEN are cut with a forced eof, the remainder
// being drained without writing.
//
// Optional feature: define UDP_ARB_FRAME_CNT_EN to add frame_cnt, one 16-bit
// wrapping count of completed frames per requester.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   req_empty/dout/sof/eof   requester FIFO heads (requester i at [8i+7:8i])
//   req_rd_en                pop for the current owner (one-hot or zero)
//   out_full                 downstream FIFO full
//   out_wr_en/din/sof/eof    downstream write port
//   grant                    one-hot owner, zero when idle
//   busy                     arbiter not idle
//   err_trunc                pulse: frame cut at MAX_FRAME_LEN
//   err_resync               pulse: non-sof head discarded while seeking sof
//   frame_cnt                (UDP_ARB_FRAME_CNT_EN only) per-requester counts
module udp_frame_arbiter
  import udp_arb_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req_empty,
  input  logic [BYTE_W*N_REQ-1:0]   req_dout,
  input  logic [N_REQ-1:0]          req_sof,
  input  logic [N_REQ-1:0]          req_eof,
  output logic [N_REQ-1:0]          req_rd_en,
  input  logic                      out_full,
  output logic                      out_wr_en,
  output logic [BYTE_W-1:0]         out_din,
  output logic                      out_wr_sof,
  output logic                      out_wr_eof,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic                      err_trunc,
  output logic                      err_resync
`ifdef UDP_ARB_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W*N_REQ-1:0] frame_cnt
`endif
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [LEN_CNT_W-1:0] LAST_IDX = LEN_CNT_W'(MAX_FRAME_LEN - 1);

  arb_state_t           r_state;
  logic [N_REQ-1:0]     r_grant;
  logic [PTR_W-1:0]     r_owner;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [LEN_CNT_W-1:0] r_byte_cnt;
  logic                 r_seek;

  logic [N_REQ-1:0]  w_arb_grant;
  logic              w_arb_valid;
  logic [PTR_W-1:0]  w_arb_idx;
  logic              w_head_empty;
  logic [BYTE_W-1:0] w_head_data;
  logic              w_head_sof;
  logic              w_head_eof;
  logic              w_at_limit;
  logic              w_seek_pop;
  logic              w_xfer;
  logic              w_flush_pop;
  logic              w_trunc;
  logic [PTR_W-1:0]  w_next_ptr;

  rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
    .i_req   (~req_empty),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant),
    .o_valid (w_arb_valid)
  );

  // One-hot arbiter result to an index so the owner's head can be muxed.
  always_comb begin
    w_arb_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_arb_grant[k]) w_arb_idx = PTR_W'(k);
    end
  end

  assign w_head_empty = req_empty[r_owner];
  assign w_head_data  = req_dout[int'(r_owner)*BYTE_W +: BYTE_W];
  assign w_head_sof   = req_sof[r_owner];
  assign w_head_eof   = req_eof[r_owner];
  assign w_at_limit   = (r_byte_cnt == LAST_IDX);

  // While seeking, a non-sof head is dropped regardless of out_full; a sof
  // head ends the seek and becomes an ordinary transfer.
  assign w_seek_pop  = (r_state == ARB_STREAM) & r_seek & ~w_head_empty & ~w_head_sof;
  assign w_xfer      = (r_state == ARB_STREAM) & ~w_head_empty & ~out_full &
                       ~(r_seek & ~w_head_sof);
  assign w_flush_pop = (r_state == ARB_FLUSH) & ~w_head_empty;
  assign w_trunc     = w_xfer & w_at_limit & ~w_head_eof;

  assign w_next_ptr = (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);

  // Data path is combinational from the owner's head so a byte moves in the
  // same cycle it is presented; everything is zero outside a transfer.
  always_comb begin
    req_rd_en  = (w_seek_pop | w_xfer | w_flush_pop) ? r_grant : '0;
    out_wr_en  = w_xfer;
    out_din    = w_xfer ? w_head_data : '0;
    out_wr_sof = w_xfer & w_head_sof;
    out_wr_eof = w_xfer & (w_head_eof | w_at_limit);
    err_trunc  = w_trunc;
    err_resync = w_seek_pop;
  end

  assign grant = r_grant;
  assign busy  = (r_state != ARB_IDLE);

  // Arbiter FSM: IDLE picks an owner, STREAM moves one frame, FLUSH drains
  // the tail of a truncated frame. The rr pointer only moves when a frame
  // completes, so an owner keeps the port for its whole frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ARB_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_byte_cnt <= '0;
      r_seek     <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_arb_valid) begin
            r_state    <= ARB_STREAM;
            r_grant    <= w_arb_grant;
            r_owner    <= w_arb_idx;
            r_byte_cnt <= '0;
            r_seek     <= 1'b1;
          end
        end
        ARB_STREAM: begin
          if (w_xfer) begin
            r_seek <= 1'b0;
            if (w_head_eof) begin
              r_state    <= ARB_IDLE;
              r_grant    <= '0;
              r_rr_ptr   <= w_next_ptr;
              r_byte_cnt <= '0;
            end else if (w_at_limit) begin
              r_state    <= ARB_FLUSH;
              r_byte_cnt <= '0;
            end else begin
              r_byte_cnt <= r_byte_cnt + LEN_CNT_W'(1);
            end
          end
        end
        ARB_FLUSH: begin
          if (w_flush_pop && w_head_eof) begin
            r_state  <= ARB_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

`ifdef UDP_ARB_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_cnt [N_REQ];

  // A frame counts as complete on its eof write or on the truncating write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) r_frame_cnt[i] <= '0;
    end else if ((w_xfer && w_head_eof) || w_trunc) begin
      r_frame_cnt[r_owner] <= r_frame_cnt[r_owner] + FRAME_CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_frame_cnt
    assign frame_cnt[FRAME_CNT_W*gi +: FRAME_CNT_W] = r_frame_cnt[gi];
  end
`endif

endmodule

// File: tb/tb_udp_frame_arbiter.sv
// Testbench for udp_frame_arbiter (N_REQ=2, MAX_FRAME_LEN=8).
// Requester FIFOs are modelled as queues; a frame-level reference model
// predicts the written byte stream, owners and error pulse counts.
module tb_udp_frame_arbiter;

  localparam int N      = 2;
  localparam int MAXLEN = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } tb_byte_t;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic [N-1:0]   req_empty, req_sof, req_eof, req_rd_en, grant;
  logic [8*N-1:0] req_dout;
  logic           out_full, out_wr_en, out_wr_sof, out_wr_eof, busy, err_trunc, err_resync;
  logic [7:0]     out_din;
`ifdef UDP_ARB_FRAME_CNT_EN
  logic [16*N-1:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  udp_frame_arbiter #(.N_REQ(N), .MAX_FRAME_LEN(MAXLEN)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_empty  (req_empty),
    .req_dout   (req_dout),
    .req_sof    (req_sof),
    .req_eof    (req_eof),
    .req_rd_en  (req_rd_en),
    .out_full   (out_full),
    .out_wr_en  (out_wr_en),
    .out_din    (out_din),
    .out_wr_sof (out_wr_sof),
    .out_wr_eof (out_wr_eof),
    .grant      (grant),
    .busy       (busy),
    .err_trunc  (err_trunc),
    .err_resync (err_resync)
`ifdef UDP_ARB_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  tb_byte_t reqQ[N][$];
  tb_byte_t modelQ[N][$];
  tb_byte_t outLog[$];
  int       outOwner[$];
  int       outCyc[$];
  tb_byte_t expQ[$];
  int       expOwner[$];
  int       truncCnt, resyncCnt, violCnt, stallViol, cycNum;
  int       expTrunc, expResync, modelRr;
  int       expFrames[N];
  int       checks = 0;
  int       errors = 0;

  // Present queue heads (random junk on empty requesters).
  task automatic driveInputs(input logic full);
    for (int i = 0; i < N; i++) begin
      if (reqQ[i].size() > 0) begin
        req_empty[i]       = 1'b0;
        req_dout[8*i +: 8] = reqQ[i][0].d;
        req_sof[i]         = reqQ[i][0].sof;
        req_eof[i]         = reqQ[i][0].eof;
      end else begin
        req_empty[i]       = 1'b1;
        req_dout[8*i +: 8] = 8'($urandom);
        req_sof[i]         = 1'($urandom);
        req_eof[i]         = 1'($urandom);
      end
    end
    out_full = full;
  endtask

  // One clock: drive at negedge, sample 1 ns later, pop after the posedge.
  task automatic runCycle(input logic full);
    logic [N-1:0] rdSnap;
    int owner;
    @(negedge clk);
    driveInputs(full);
    #1;
    owner = -1;
    for (int i = 0; i < N; i++) if (grant[i]) owner = i;
    if (out_wr_en) begin
      if (out_full) violCnt++;
      if (req_rd_en !== grant) violCnt++;
      outLog.push_back({out_din, out_wr_sof, out_wr_eof});
      outOwner.push_back(owner);
      outCyc.push_back(cycNum);
    end
    if (full && (out_wr_en || req_rd_en != '0)) stallViol++;
    if (err_trunc) truncCnt++;
    if (err_resync) resyncCnt++;
    if ((req_rd_en & ~grant) != '0 || (req_rd_en & req_empty) != '0 ||
        $countones(req_rd_en) > 1 || $countones(grant) > 1) violCnt++;
    rdSnap = req_rd_en;
    cycNum++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (rdSnap[i]) void'(reqQ[i].pop_front());
  endtask

  task automatic pushByte(input int r, input logic [7:0] d, input logic sof, input logic eof);
    tb_byte_t b;
    b.d = d; b.sof = sof; b.eof = eof;
    reqQ[r].push_back(b);
    modelQ[r].push_back(b);
  endtask

  task automatic pushFrame(input int r, input int len);
    for (int k = 0; k < len; k++) pushByte(r, 8'($urandom), k == 0, k == len - 1);
  endtask

  task automatic pushGarbage(input int r, input int n);
    for (int k = 0; k < n; k++) pushByte(r, 8'($urandom), 1'b0, 1'($urandom));
  endtask

  task automatic clearLogs();
    outLog.delete(); outOwner.delete(); outCyc.delete();
    truncCnt = 0; resyncCnt = 0; violCnt = 0; stallViol = 0; cycNum = 0;
  endtask

  // Frame-level reference: round-robin over non-empty queues, drop leading
  // non-sof bytes, cut at MAXLEN and discard the rest through eof.
  task automatic buildExpected();
    tb_byte_t b;
    int g, len;
    bit found, done;
    expQ.delete(); expOwner.delete(); expTrunc = 0; expResync = 0;
    forever begin
      found = 0; g = 0;
      for (int k = 0; k < N; k++)
        if (!found && modelQ[(modelRr + k) % N].size() > 0) begin
          found = 1; g = (modelRr + k) % N;
        end
      if (!found) break;
      while (modelQ[g].size() > 0 && !modelQ[g][0].sof) begin
        b = modelQ[g].pop_front(); expResync++;
      end
      if (modelQ[g].size() == 0) break;
      len = 0; done = 0;
      while (!done && modelQ[g].size() > 0) begin
        b = modelQ[g].pop_front(); len++;
        if (b.eof) begin
          expQ.push_back(b); expOwner.push_back(g); done = 1;
        end else if (len == MAXLEN) begin
          b.eof = 1'b1; expQ.push_back(b); expOwner.push_back(g); expTrunc++; done = 1;
          while (modelQ[g].size() > 0) begin
            b = modelQ[g].pop_front();
            if (b.eof) break;
          end
        end else begin
          expQ.push_back(b); expOwner.push_back(g);
        end
      end
      expFrames[g]++;
      modelRr = (g + 1) % N;
    end
  endtask

  task automatic drain(input int maxCyc, input int fullPct, output bit timedOut);
    int n = 0;
    timedOut = 0;
    while (!(reqQ[0].size() == 0 && reqQ[1].size() == 0 && !busy)) begin
      if (n >= maxCyc) begin timedOut = 1; break; end
      runCycle($urandom_range(99) < fullPct);
      n++;
    end
  endtask

  function automatic int countLogDiffs();
    int n = 0;
    if (outLog.size() != expQ.size()) return -1;
    for (int k = 0; k < outLog.size(); k++)
      if (outLog[k] !== expQ[k] || outOwner[k] != expOwner[k]) n++;
    return n;
  endfunction

  task automatic test_reset();
    driveInputs(1'b0);
    #1 reset_n = 1'b0;
    modelRr = 0;
    for (int i = 0; i < N; i++) expFrames[i] = 0;
    #11;
    checks++; if (grant !== '0) begin errors++; $display("[TB] FAIL reset_grant got %b want 0", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if ({req_rd_en, out_wr_en, out_din, out_wr_sof, out_wr_eof, err_trunc, err_resync} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs rd_en %b wr_en %b din %h want all 0", req_rd_en, out_wr_en, out_din);
    end
`ifdef UDP_ARB_FRAME_CNT_EN
    checks++; if (frame_cnt !== '0) begin errors++; $display("[TB] FAIL reset_frame_cnt got %h want 0", frame_cnt); end
`endif
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_single_frame();
    bit to;
    int d;
    clearLogs(); pushFrame(0, 4); buildExpected();
    drain(100, 0, to);
    d = countLogDiffs();
    checks++; if (to) begin errors++; $display("[TB] FAIL single_timeout got timeout want drained"); end
    checks++; if (d != 0) begin errors++; $display("[TB] FAIL single_data diffs %0d got %0d bytes want %0d", d, outLog.size(), expQ.size()); end
    checks++; if (outCyc.size() < 1 || outCyc[0] != 1) begin
      errors++; $display("[TB] FAIL single_latency got first write cycle %0d want 1", outCyc.size() ? outCyc[0] : -1);
    end
    checks++; if (grant !== '0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle got grant %b busy %b want 00 0", grant, busy); end
  endtask

  task automatic test_alternation();
    bit to;
    int d, badGap;
    clearLogs();
    for (int f = 0; f < 3; f++) begin pushFrame(0, 5); pushFrame(1, 5); end
    buildExpected();
    drain(200, 0, to);
    d = countLogDiffs();
    checks++; if (to || d != 0) begin errors++; $display("[TB] FAIL alt_data timeout %0d diffs %0d want 0 0", to, d); end
    badGap = 0;
    if (outLog.size() == 30)
      for (int k = 0; k < 5; k++)
        if (outCyc[5*k+5] - outCyc[5*k+4] != 2 || outOwner[5*k+5] == outOwner[5*k]) badGap++;
    checks++; if (outLog.size() != 30 || badGap != 0) begin
      errors++; $display("[TB] FAIL alt_gap got %0d bad boundaries over %0d bytes want 0 over 30", badGap, outLog.size());
    end
`ifdef UDP_ARB_FRAME_CNT_EN
    for (int i = 0; i < N; i++) begin
      checks++; if (frame_cnt[16*i +: 16] !== 16'(expFrames[i])) begin
        errors++; $display("[TB] FAIL alt_frame_cnt%0d got %0d want %0d", i, frame_cnt[16*i +: 16], expFrames[i]);
      end
    end
`endif
  endtask

  task automatic test_backpressure();
    bit to;
    int d;
    clearLogs(); pushFrame(0, 6); buildExpected();
    for (int c = 0; c < 6; c++) runCycle(c >= 3);
    drain(100, 0, to);
    d = countLogDiffs();
    checks++; if (stallViol != 0) begin errors++; $display("[TB] FAIL bp_stall got %0d active cycles while full want 0", stallViol); end
    checks++; if (to || d != 0) begin errors++; $display("[TB] FAIL bp_data timeout %0d diffs %0d want 0 0", to, d); end
    checks++; if (outCyc.size() < 3 || outCyc[2] != 6) begin
      errors++; $display("[TB] FAIL bp_resume got third write cycle %0d want 6", outCyc.size() > 2 ? outCyc[2] : -1);
    end
  endtask

  task automatic test_truncation();
    bit to;
    int d;
    clearLogs(); pushFrame(0, 12); pushFrame(0, MAXLEN); pushFrame(1, 3); buildExpected();
    drain(300, 20, to);
    d = countLogDiffs();
    checks++; if (to || d != 0) begin errors++; $display("[TB] FAIL trunc_data timeout %0d diffs %0d want 0 0", to, d); end
    checks++; if (truncCnt != expTrunc || expTrunc != 1) begin
      errors++; $display("[TB] FAIL trunc_pulses got %0d want %0d", truncCnt, expTrunc);
    end
    checks++; if (violCnt != 0) begin errors++; $display("[TB] FAIL trunc_protocol got %0d violations want 0", violCnt); end
`ifdef UDP_ARB_FRAME_CNT_EN
    checks++; if (frame_cnt[15:0] !== 16'(expFrames[0])) begin
      errors++; $display("[TB] FAIL trunc_frame_cnt got %0d want %0d", frame_cnt[15:0], expFrames[0]);
    end
`endif
  endtask

  task automatic test_resync();
    bit to;
    int d;
    clearLogs(); pushGarbage(1, 2); pushFrame(1, 3); buildExpected();
    for (int c = 0; c < 3; c++) runCycle(c >= 1);
    checks++; if (resyncCnt != 2) begin errors++; $display("[TB] FAIL resync_while_full got %0d pulses want 2", resyncCnt); end
    drain(100, 0, to);
    d = countLogDiffs();
    checks++; if (to || d != 0 || resyncCnt != expResync) begin
      errors++; $display("[TB] FAIL resync_data timeout %0d diffs %0d pulses %0d want 0 0 %0d", to, d, resyncCnt, expResync);
    end
  endtask

  task automatic test_random();
    bit to;
    int d;
    for (int it = 0; it < 20; it++) begin
      clearLogs();
      for (int r = 0; r < N; r++)
        for (int f = 0; f < int'($urandom_range(3)); f++) begin
          pushGarbage(r, $urandom_range(2));
          pushFrame(r, $urandom_range(12, 1));
        end
      buildExpected();
      drain(2000, $urandom_range(60), to);
      d = countLogDiffs();
      checks++; if (to || d != 0) begin errors++; $display("[TB] FAIL rand%0d_data timeout %0d diffs %0d want 0 0", it, to, d); end
      checks++; if (truncCnt != expTrunc || resyncCnt != expResync) begin
        errors++; $display("[TB] FAIL rand%0d_pulses got trunc %0d resync %0d want %0d %0d", it, truncCnt, resyncCnt, expTrunc, expResync);
      end
      checks++; if (violCnt != 0) begin errors++; $display("[TB] FAIL rand%0d_protocol got %0d violations want 0", it, violCnt); end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    int d;
    clearLogs(); pushFrame(1, 10);
    for (int c = 0; c < 4; c++) runCycle(1'b0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({grant, busy, req_rd_en, out_wr_en, out_wr_eof, err_trunc, err_resync} !== '0) begin
      errors++; $display("[TB] FAIL midreset_outputs got grant %b busy %b rd %b wr %b want 0", grant, busy, req_rd_en, out_wr_en);
    end
    for (int i = 0; i < N; i++) begin reqQ[i].delete(); modelQ[i].delete(); expFrames[i] = 0; end
    modelRr = 0;
`ifdef UDP_ARB_FRAME_CNT_EN
    checks++; if (frame_cnt !== '0) begin errors++; $display("[TB] FAIL midreset_frame_cnt got %h want 0", frame_cnt); end
`endif
    pushFrame(1, 3); pushFrame(0, 3);
    driveInputs(1'b0);
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    clearLogs(); buildExpected();
    drain(100, 0, to);
    d = countLogDiffs();
    checks++; if (outOwner.size() < 1 || outOwner[0] != 0) begin
      errors++; $display("[TB] FAIL midreset_first_owner got %0d want 0", outOwner.size() ? outOwner[0] : -1);
    end
    checks++; if (to || d != 0) begin errors++; $display("[TB] FAIL midreset_data timeout %0d diffs %0d want 0 0", to, d); end
`ifdef UDP_ARB_FRAME_CNT_EN
    checks++; if (frame_cnt !== {16'd1, 16'd1}) begin errors++; $display("[TB] FAIL midreset_count got %h want 00010001", frame_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_alternation();
    test_backpressure();
    test_truncation();
    test_resync();
    test_random();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
